// File: rtl/mmio_if.sv
// Bus bundle between the EX/WB pipeline stages, the UART and mmio_ctrl.
// The controller sits on the slave side; the core/UART environment drives the master side.
interface mmio_if;
  logic [31:0] ex_addr_i;
  logic [31:0] ex_wdata_i;
  logic        ex_we_i;
  logic        ex_re_i;
  logic        stall_i;
  logic        inst_retire_i;
  logic [7:0]  uart_tx_data_o;
  logic        uart_tx_valid_o;
  logic        uart_tx_ready_i;
  logic [7:0]  uart_rx_data_i;
  logic        uart_rx_valid_i;
  logic        uart_rx_ready_o;
  logic [31:0] uart_data_o;
  logic        mmio_hit_o;

  modport slave (
    input  ex_addr_i, ex_wdata_i, ex_we_i, ex_re_i, stall_i, inst_retire_i,
    input  uart_tx_ready_i, uart_rx_data_i, uart_rx_valid_i,
    output uart_tx_data_o, uart_tx_valid_o, uart_rx_ready_o,
    output uart_data_o, mmio_hit_o
  );

  modport master (
    output ex_addr_i, ex_wdata_i, ex_we_i, ex_re_i, stall_i, inst_retire_i,
    output uart_tx_ready_i, uart_rx_data_i, uart_rx_valid_i,
    input  uart_tx_data_o, uart_tx_valid_o, uart_rx_ready_o,
    input  uart_data_o, mmio_hit_o
  );
endinterface

// File: rtl/mmio_ctrl.sv
// MMIO controller for the 0x8000_00xx window: UART tx/rx handshakes plus
// cycle and retired-instruction counters, with registered read data to WB.
module mmio_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic  clk,
  input  logic  rst_n,
  mmio_if.slave bus
);

  localparam logic [7:0] OFF_STATUS = 8'h00;
  localparam logic [7:0] OFF_RX     = 8'h04;
  localparam logic [7:0] OFF_TX     = 8'h08;
  localparam logic [7:0] OFF_CYCLE  = 8'h10;
  localparam logic [7:0] OFF_INSTR  = 8'h14;
  localparam logic [7:0] OFF_CLEAR  = 8'h18;

  typedef enum logic {TX_IDLE, TX_PEND} tx_state_t;

  tx_state_t   tx_state, tx_state_nxt;
  logic [7:0]  tx_byte, tx_byte_nxt;
  logic        rx_full;
  logic [7:0]  rx_byte;
  logic [31:0] cycle_cnt;
  logic [31:0] instr_cnt;
  logic [31:0] rd_data;
  logic        rd_hit;
  logic [31:0] uart_data_q;
  logic        mmio_hit_q;

  // Address decode: offset within the window, qualified by a non-stalled request.
  logic [31:0] addr_off;
  logic        in_window;
  logic        req_wr, req_rd;
  logic        wr_tx, wr_clear, rd_rx;
  logic        rx_capture, rx_pop;

  assign addr_off  = bus.ex_addr_i - BASE_ADDR;
  assign in_window = (addr_off[31:8] == 24'd0);
  // A simultaneous load and store performs only the store.
  assign req_wr    = bus.ex_we_i & ~bus.stall_i;
  assign req_rd    = bus.ex_re_i & ~bus.ex_we_i & ~bus.stall_i;
  assign wr_tx     = req_wr & in_window & (addr_off[7:0] == OFF_TX);
  assign wr_clear  = req_wr & in_window & (addr_off[7:0] == OFF_CLEAR);
  assign rd_rx     = req_rd & in_window & (addr_off[7:0] == OFF_RX);

  // Ready is pure state, so capture and pop can never coincide.
  assign rx_capture = bus.uart_rx_valid_i & ~rx_full;
  assign rx_pop     = rd_rx & rx_full;

  // TX state register and held transmit byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_byte  <= 8'h00;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
      tx_state <= tx_state_nxt;
      tx_byte  <= tx_byte_nxt;
    end
  end

  // TX next-state: latch a byte from IDLE, release it on the ready handshake.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    tx_state_nxt = tx_state;
    tx_byte_nxt  = tx_byte;
    unique case (tx_state)
      TX_IDLE: begin
        if (wr_tx) begin
          tx_state_nxt = TX_PEND;
          tx_byte_nxt  = bus.ex_wdata_i[7:0];
        end
      end
      TX_PEND: begin
        // Writes to the tx register are dropped here; software polls status.
        if (bus.uart_tx_ready_i) tx_state_nxt = TX_IDLE;
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  // One-entry RX buffer: capture when empty, pop on a read of the rx register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_full <= 1'b0;
      // NOTE: the data byte is reset too, so a stale read after reset returns a known 0.
      rx_byte <= 8'h00;
    end else if (rx_capture) begin
      rx_full <= 1'b1;
      rx_byte <= bus.uart_rx_data_i;
    end else if (rx_pop) begin
      rx_full <= 1'b0;
    end
  end

  // Free-running counters; a clear write wins over that cycle's increments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= 32'd0;
      instr_cnt <= 32'd0;
    end else if (wr_clear) begin
      cycle_cnt <= 32'd0;
      instr_cnt <= 32'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      instr_cnt <= instr_cnt + {31'd0, bus.inst_retire_i};
    end
  end

  // Read mux over pre-edge state; undefined addresses return 0 with no hit.
  always_comb begin
    rd_data = 32'd0;
    rd_hit  = 1'b0;
    if (req_rd && in_window) begin
      unique case (addr_off[7:0])
        OFF_STATUS: begin rd_data = {30'd0, rx_full, tx_state == TX_IDLE}; rd_hit = 1'b1; end
        OFF_RX:     begin rd_data = {24'd0, rx_byte};                      rd_hit = 1'b1; end
        OFF_CYCLE:  begin rd_data = cycle_cnt;                             rd_hit = 1'b1; end
        OFF_INSTR:  begin rd_data = instr_cnt;                             rd_hit = 1'b1; end
        default:    ;
      endcase
    end
  end

  // Register read data for writeback, one cycle after EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_data_q <= 32'd0;
      mmio_hit_q  <= 1'b0;
    end else begin
      uart_data_q <= rd_data;
      mmio_hit_q  <= rd_hit;
    end
  end

  assign bus.uart_tx_valid_o = (tx_state == TX_PEND);
  assign bus.uart_tx_data_o  = tx_byte;
  assign bus.uart_rx_ready_o = ~rx_full;
  assign bus.uart_data_o     = uart_data_q;
  assign bus.mmio_hit_o      = mmio_hit_q;

endmodule

// File: tb/tb_mmio_ctrl.sv
// Self-checking bench for mmio_ctrl: a register-level model predicts all
// outputs every cycle, and directed scenarios pin it with literal values.
module tb_mmio_ctrl;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic force_wrap = 1'b0;
  int   valid_cycles;

  mmio_if bus ();

  mmio_ctrl #(.BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: what the register map says must hold after each edge.
  logic        m_tx_pend, m_rx_full;
  logic [7:0]  m_tx_byte, m_rx_byte;
  logic [31:0] m_cyc, m_ins, e_data;
  logic        e_hit;
  logic [31:0] off, cyc_now;
  logic        wr_ok, rd_ok;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tx_pend <= 1'b0; m_tx_byte <= 8'h00;
      m_rx_full <= 1'b0; m_rx_byte <= 8'h00;
      m_cyc <= 32'd0; m_ins <= 32'd0;
      e_data <= 32'd0; e_hit <= 1'b0;
    end else begin
      cyc_now = force_wrap ? 32'hFFFF_FFFF : m_cyc;
      off   = bus.ex_addr_i - BASE;
      wr_ok = bus.ex_we_i && !bus.stall_i;
      rd_ok = bus.ex_re_i && !bus.ex_we_i && !bus.stall_i;
      e_data <= 32'd0;
      e_hit  <= 1'b0;
      if (rd_ok) begin
        case (off)
          32'h00: begin e_data <= {30'd0, m_rx_full, !m_tx_pend}; e_hit <= 1'b1; end
          32'h04: begin e_data <= {24'd0, m_rx_byte}; e_hit <= 1'b1; end
          32'h10: begin e_data <= cyc_now; e_hit <= 1'b1; end
          32'h14: begin e_data <= m_ins; e_hit <= 1'b1; end
          default: ;
        endcase
      end
      if (rd_ok && off == 32'h04 && m_rx_full) m_rx_full <= 1'b0;
      else if (bus.uart_rx_valid_i && !m_rx_full) begin
        m_rx_full <= 1'b1;
        m_rx_byte <= bus.uart_rx_data_i;
      end
      if (m_tx_pend) begin
        if (bus.uart_tx_ready_i) m_tx_pend <= 1'b0;
      end else if (wr_ok && off == 32'h08) begin
        m_tx_pend <= 1'b1;
        m_tx_byte <= bus.ex_wdata_i[7:0];
      end
      if (wr_ok && off == 32'h18) begin
        m_cyc <= 32'd0;
        m_ins <= 32'd0;
      end else begin
        m_cyc <= cyc_now + 32'd1;
        m_ins <= m_ins + (bus.inst_retire_i ? 32'd1 : 32'd0);
      end
    end
  end

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    check("m_uart_data", bus.uart_data_o, e_data);
    check("m_mmio_hit", {31'd0, bus.mmio_hit_o}, {31'd0, e_hit});
    check("m_tx_valid", {31'd0, bus.uart_tx_valid_o}, {31'd0, m_tx_pend});
    check("m_tx_data", {24'd0, bus.uart_tx_data_o}, {24'd0, m_tx_byte});
    check("m_rx_ready", {31'd0, bus.uart_rx_ready_o}, {31'd0, !m_rx_full});
  end

  task automatic idle();
    bus.ex_addr_i = 32'd0; bus.ex_wdata_i = 32'd0;
    bus.ex_we_i = 1'b0; bus.ex_re_i = 1'b0;
    bus.stall_i = 1'b0; bus.inst_retire_i = 1'b0;
  endtask

  task automatic rd(input logic [7:0] o);
    idle();
    bus.ex_addr_i = BASE + {24'd0, o};
    bus.ex_re_i = 1'b1;
  endtask

  task automatic wr(input logic [7:0] o, input logic [31:0] d);
    idle();
    bus.ex_addr_i = BASE + {24'd0, o};
    bus.ex_wdata_i = d;
    bus.ex_we_i = 1'b1;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    bus.uart_tx_ready_i = 1'b0;
    bus.uart_rx_data_i  = 8'h00;
    bus.uart_rx_valid_i = 1'b0;
    repeat (2) step();
    check("rst_data", bus.uart_data_o, 32'd0);
    check("rst_rx_ready", {31'd0, bus.uart_rx_ready_o}, 32'd1);
    rst_n = 1'b1;

    // Cycle counter after five edges, then idle status.
    repeat (5) step();
    rd(8'h10); step();
    check("cycle_at_5", bus.uart_data_o, 32'd5);
    check("cycle_hit", {31'd0, bus.mmio_hit_o}, 32'd1);
    rd(8'h00); step();
    check("status_idle", bus.uart_data_o, 32'h1);

    // TX with ready held low for three cycles; second write dropped.
    wr(8'h08, 32'h0000_1241); step();
    valid_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      idle();
      if (i == 0) wr(8'h08, 32'h42);
      if (i == 1) rd(8'h00);
      bus.uart_tx_ready_i = (i == 3);
      if (bus.uart_tx_valid_o) begin
        valid_cycles++;
        check("tx_data_stable", {24'd0, bus.uart_tx_data_o}, 32'h41);
      end
      if (i == 2) check("status_pend", bus.uart_data_o, 32'h0);
      step();
    end
    bus.uart_tx_ready_i = 1'b0;
    check("tx_valid_cycles", valid_cycles, 32'd4);
    rd(8'h00); step();
    check("status_after_tx", bus.uart_data_o, 32'h1);

    // RX capture, pop, stale read.
    idle();
    bus.uart_rx_data_i = 8'h5A; bus.uart_rx_valid_i = 1'b1; step();
    bus.uart_rx_valid_i = 1'b0;
    check("rx_ready_full", {31'd0, bus.uart_rx_ready_o}, 32'd0);
    rd(8'h00); step();
    check("status_rx_full", bus.uart_data_o, 32'h3);
    rd(8'h04); step();
    check("rx_pop_data", bus.uart_data_o, 32'h5A);
    check("rx_ready_after_pop", {31'd0, bus.uart_rx_ready_o}, 32'd1);
    rd(8'h00); step();
    check("status_after_pop", bus.uart_data_o, 32'h1);
    rd(8'h04); step();
    check("rx_stale", bus.uart_data_o, 32'h5A);
    rd(8'h00); step();
    check("status_after_stale", bus.uart_data_o, 32'h1);

    // Unmapped read, load+store together, stalled read.
    rd(8'h0C); step();
    check("unmapped_hit", {31'd0, bus.mmio_hit_o}, 32'd0);
    rd(8'h10); bus.ex_we_i = 1'b1; step();
    check("we_re_data", bus.uart_data_o, 32'd0);
    rd(8'h10); bus.stall_i = 1'b1; step();
    check("stall_rd_hit", {31'd0, bus.mmio_hit_o}, 32'd0);

    // Seven retires, then clear with a retire in the clear cycle.
    for (int i = 0; i < 7; i++) begin
      idle(); bus.inst_retire_i = 1'b1; step();
    end
    rd(8'h14); step();
    check("instr_7", bus.uart_data_o, 32'd7);
    wr(8'h18, 32'd0); bus.inst_retire_i = 1'b1; step();
    rd(8'h10); step();
    check("cycle_cleared", bus.uart_data_o, 32'd0);
    rd(8'h14); step();
    check("instr_cleared", bus.uart_data_o, 32'd0);

    // Cycle counter wrap.
    rd(8'h10);
    force_wrap = 1'b1;
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    #2 release dut.cycle_cnt;
    step();
    force_wrap = 1'b0;
    check("cycle_max", bus.uart_data_o, 32'hFFFF_FFFF);
    rd(8'h10); step();
    check("cycle_wrap", bus.uart_data_o, 32'd0);

    // Stalled tx write has no effect.
    wr(8'h08, 32'h41); bus.stall_i = 1'b1; step();
    check("stall_no_tx", {31'd0, bus.uart_tx_valid_o}, 32'd0);

    // Reset mid-read and mid-PEND with an rx byte held.
    wr(8'h08, 32'h77);
    bus.uart_rx_data_i = 8'h33; bus.uart_rx_valid_i = 1'b1; step();
    bus.uart_rx_valid_i = 1'b0;
    rd(8'h10);
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    check("arst_data", bus.uart_data_o, 32'd0);
    check("arst_hit", {31'd0, bus.mmio_hit_o}, 32'd0);
    check("arst_tx_valid", {31'd0, bus.uart_tx_valid_o}, 32'd0);
    check("arst_tx_data", {24'd0, bus.uart_tx_data_o}, 32'd0);
    check("arst_rx_ready", {31'd0, bus.uart_rx_ready_o}, 32'd1);
    idle(); step();
    rst_n = 1'b1;
    rd(8'h00); step();
    check("status_after_rst", bus.uart_data_o, 32'h1);
    idle(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mmio_ctrl.md
# mmio_ctrl

Memory-mapped I/O controller for the RISC-V core's 0x8000_00xx window. It sequences the byte-wide UART transmit/receive handshakes and holds the cycle and instruction counters. It returns registered read data to the writeback stage's UART data input, one cycle after the access is presented in EX. It is the single owner of all UART and counter state; the writeback mux only selects this block's data.

## Interface
Parameters:
- BASE_ADDR, 32'h8000_0000, base of the MMIO window; register offsets below are relative to it

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- ex_addr_i  in  32  byte address of the load/store in EX (ALU result)
- ex_wdata_i  in  32  store data; only [7:0] used
- ex_we_i  in  1  store in EX this cycle
- ex_re_i  in  1  load in EX this cycle
- stall_i  in  1  pipeline stall; ignore EX request, no side effects
- inst_retire_i  in  1  one instruction retired this cycle
- uart_tx_data_o  out  8  byte to UART transmitter
- uart_tx_valid_o  out  1  tx byte pending
- uart_tx_ready_i  in  1  transmitter accepts byte
- uart_rx_data_i  in  8  byte from UART receiver
- uart_rx_valid_i  in  1  rx byte offered
- uart_rx_ready_o  out  1  controller can accept rx byte
- uart_data_o  out  32  registered read data to writeback
- mmio_hit_o  out  1  registered: previous-cycle read hit a defined register

## Operation
Register map (word offsets from BASE_ADDR):
- 0x00 R: status {30'b0, rx_full, ~tx_pending}
- 0x04 R: rx data {24'b0, rx_byte}; read pops (clears rx_full)
- 0x08 W: tx data; captures ex_wdata_i[7:0]
- 0x10 R: cycle counter
- 0x14 R: instruction counter
- 0x18 W: any write clears both counters
- All other addresses: reads return 0 with mmio_hit_o=0; writes are ignored.
- A request counts only when stall_i=0. ex_we_i and ex_re_i both high: the write is performed, the read is ignored (uart_data_o=0, mmio_hit_o=0).

TX path (states IDLE, PEND):
- IDLE: uart_tx_valid_o=0. A write to 0x08 latches the byte -> PEND.
- PEND: uart_tx_valid_o=1, uart_tx_data_o stable. uart_tx_ready_i=1 -> IDLE next cycle.
- A write to 0x08 while in PEND is dropped; software polls status bit 0.

RX path (one-entry buffer):
- uart_rx_ready_o = ~rx_full (registered state, no combinational path from the inputs).
- uart_rx_valid_i & uart_rx_ready_o: capture the byte, set rx_full.
- Reading 0x04 when rx_full=1 returns the byte and clears rx_full. When rx_full=0 it returns the stale byte and changes no state.

Counters:
- Both counters are 32-bit unsigned and wrap from 0xFFFF_FFFF to 0.
- The cycle counter increments every cycle. The instruction counter increments when inst_retire_i=1.
- A write to 0x18 sets both counters to 0 next cycle; that cycle's increments are suppressed.
- Reads return the value held at the start of the access cycle.

## Timing
- Reset (rst_n=0, asynchronous): uart_data_o=0, mmio_hit_o=0, uart_tx_valid_o=0, uart_tx_data_o=0, uart_rx_ready_o=1, rx_full=0, both counters=0, TX state IDLE.
- Read latency 1: address presented at edge N gives uart_data_o/mmio_hit_o valid after edge N+1, held until the next edge.
- A cycle with no valid read drives uart_data_o=0 and mmio_hit_o=0.
- A TX write at edge N raises uart_tx_valid_o after edge N; status bit 0 reads 0 from cycle N+1.
- An RX capture at edge N drops uart_rx_ready_o after edge N. A pop at edge M raises it after edge M, so the earliest next capture is edge M+1.
- Pop and capture can never occur on the same edge, because ready is low whenever full.
- Reset asserted mid-transfer aborts the pending tx byte and discards the rx byte; no handshake completes.

## Test plan
- Reset then read 0x10 at cycle 5 -> uart_data_o=5 one cycle later; read 0x00 -> 0x1.
- Write 0x41 to 0x08 with uart_tx_ready_i held 0 for 3 cycles -> uart_tx_valid_o=1 and data 0x41 stable for 4 cycles. A second write of 0x42 during that time is dropped. Status reads 0x0 until the handshake, then 0x1.
- Drive rx 0x5A with uart_rx_valid_i -> uart_rx_ready_o=0 and status=0x3. Read 0x04 -> 0x0000005A, then status=0x1 and ready=1. Read 0x04 again -> 0x5A with no state change.
- Pulse inst_retire_i 7 times, then write 0x18 -> both counters read 0 at the following cycle. A retire pulse in the clear cycle is not counted.
- Force the cycle counter to 0xFFFF_FFFF -> the next read is 0. Assert stall_i during a write to 0x08 -> no tx.
- Assert rst_n=0 mid-way through a read and during PEND -> all outputs are at reset values immediately, before the next edge.
